// File: rtl/tcd1290d_line_capture.sv
// Purpose : digitise one TCD1290D line; sample adc_data SAMPLE_DLY cycles after each f2b rise and
//           stream the active pixels (dummies dropped) with start/end-of-line markers.
// Latency : sh/f2b pass through a 2-flop edge detector; a pixel is captured at edge E0+SAMPLE_DLY
//           and pix_valid rises in the following cycle.
// Backpressure : none; the consumer must take one pixel per f2b period.
// Ports   : sys_clk/sys_rst (sync, active high); enable arms new lines; sh/f2b driver timing;
//           adc_data ADC word; pix_* pixel stream; line_done/line_err per-line pulses;
//           line_cnt completed lines; busy = line in progress.
module tcd1290d_line_capture #(
    parameter int          DATA_W        = 12,
    parameter int          LINE_WIDTH    = 2100,
    parameter int          LEAD_DUMMY    = 32,
    parameter int          ACTIVE_PIXELS = 2048,
    parameter int          SAMPLE_DLY    = 6,
    parameter logic [19:0] TIMEOUT       = 20'd100000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              enable,
    input  logic              sh,
    input  logic              f2b,
    input  logic [DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              line_done,
    output logic              line_err,
    output logic [15:0]       line_cnt,
    output logic              busy
);

    localparam int IDX_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int DLY_W = (SAMPLE_DLY > 1) ? $clog2(SAMPLE_DLY) : 1;

    localparam logic [IDX_W-1:0] FIRST_ACT = IDX_W'(LEAD_DUMMY);
    localparam logic [IDX_W-1:0] LAST_ACT  = IDX_W'(LEAD_DUMMY + ACTIVE_PIXELS - 1);
    localparam logic [IDX_W-1:0] LAST_PIX  = IDX_W'(LINE_WIDTH - 1);
    localparam logic [DLY_W-1:0] DLY_LAST  = DLY_W'(SAMPLE_DLY - 1);
    localparam logic [19:0]      TO_LAST   = TIMEOUT - 20'd1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_DELAY = 2'd2;

    logic [1:0]       state;
    logic             sh_q, sh_q2, f2b_q, f2b_q2;
    logic [IDX_W-1:0] pix_idx;
    logic [DLY_W-1:0] dly_cnt;
    logic [19:0]      to_cnt;
    logic             sh_fall, f2b_rise;

    assign sh_fall  = ~sh_q & sh_q2;
    assign f2b_rise = f2b_q & ~f2b_q2;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            sh_q      <= 1'b0;
            sh_q2     <= 1'b0;
            f2b_q     <= 1'b0;
            f2b_q2    <= 1'b0;
            pix_idx   <= '0;
            dly_cnt   <= '0;
            to_cnt    <= '0;
            line_cnt  <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            line_done <= 1'b0;
            line_err  <= 1'b0;
        end else begin
            sh_q   <= sh;
            sh_q2  <= sh_q;
            f2b_q  <= f2b;
            f2b_q2 <= f2b_q;

            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            line_done <= 1'b0;
            line_err  <= 1'b0;

            // A new SH inside a line means the driver restarted: drop the partial
            // line (no pixel even if the capture point coincides) and re-arm if allowed.
            if (state != S_IDLE && sh_fall) begin
                line_err <= 1'b1;
                pix_idx  <= '0;
                to_cnt   <= '0;
                state    <= enable ? S_ARMED : S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (sh_fall && enable) begin
                            state   <= S_ARMED;
                            pix_idx <= '0;
                            to_cnt  <= '0;
                        end
                    end
                    S_ARMED: begin
                        if (f2b_rise) begin
                            state   <= S_DELAY;
                            dly_cnt <= '0;
                        end else if (to_cnt == TO_LAST) begin
                            state    <= S_IDLE;
                            line_err <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + 20'd1;
                        end
                    end
                    S_DELAY: begin
                        // Extra f2b edges here are a driver fault and are simply ignored.
                        if (dly_cnt == DLY_LAST) begin
                            if (pix_idx >= FIRST_ACT && pix_idx <= LAST_ACT) begin
                                pix_data  <= adc_data;
                                pix_valid <= 1'b1;
                                pix_sof   <= (pix_idx == FIRST_ACT);
                                pix_eol   <= (pix_idx == LAST_ACT);
                            end
                            if (pix_idx == LAST_PIX) begin
                                state     <= S_IDLE;
                                line_done <= 1'b1;
                                line_cnt  <= line_cnt + 16'd1;
                            end else begin
                                pix_idx <= pix_idx + 1'b1;
                                to_cnt  <= '0;
                                state   <= S_ARMED;
                            end
                        end else begin
                            dly_cnt <= dly_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tcd1290d_line_capture.sv
// Purpose : exercise tcd1290d_line_capture with a small line geometry against a line-level model.
// Latency : stimulus is applied on falling edges; DUT outputs are observed on falling edges.
// Backpressure : none; the bench consumes every pixel strobe.
module tb_tcd1290d_line_capture;

    localparam int          DW = 12;
    localparam int          LW = 8;
    localparam int          LD = 2;
    localparam int          AP = 4;
    localparam int          SD = 3;
    localparam logic [19:0] TO = 20'd50;

    logic          clk = 1'b0;
    logic          rst, enable, sh, f2b;
    logic [DW-1:0] adc;
    logic [DW-1:0] pix_data;
    logic          pix_valid, pix_sof, pix_eol, line_done, line_err, busy;
    logic [15:0]   line_cnt;

    tcd1290d_line_capture #(
        .DATA_W(DW), .LINE_WIDTH(LW), .LEAD_DUMMY(LD), .ACTIVE_PIXELS(AP),
        .SAMPLE_DLY(SD), .TIMEOUT(TO)
    ) dut (
        .sys_clk(clk), .sys_rst(rst), .enable(enable), .sh(sh), .f2b(f2b),
        .adc_data(adc), .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_eol(pix_eol), .line_done(line_done), .line_err(line_err),
        .line_cnt(line_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;

    // Observed stream and event counters (written only by the monitor).
    int            cyc = 0;
    logic [DW-1:0] mq_data[$];
    bit            mq_sof[$];
    bit            mq_eol[$];
    int            n_done = 0, n_err = 0, n_busy = 0;
    int            last_valid_cyc = 0, last_err_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pix_valid === 1'b1) begin
            mq_data.push_back(pix_data);
            mq_sof.push_back(pix_sof === 1'b1);
            mq_eol.push_back(pix_eol === 1'b1);
            last_valid_cyc <= cyc;
        end
        if (line_done === 1'b1) n_done <= n_done + 1;
        if (line_err === 1'b1) begin
            n_err        <= n_err + 1;
            last_err_cyc <= cyc;
        end
        if (busy === 1'b1) n_busy <= n_busy + 1;
    end

    // Line-level reference model: is a line armed, which pixel comes next.
    logic [DW-1:0] eq_data[$];
    bit            eq_sof[$];
    bit            eq_eol[$];
    bit            m_armed   = 1'b0;
    int            m_idx     = 0;
    int            exp_lines = 0;
    int            exp_err   = 0;

    task automatic step(input logic s, input logic f, input logic [DW-1:0] a);
        @(negedge clk);
        sh  = s;
        f2b = f;
        adc = a;
    endtask

    // mode 0: random ADC word every cycle, 1: ADC = pixel index,
    // 2: 0xAAA before pixel offset sw, 0x555 from offset sw onward.
    task automatic drive_line(input int npix, input bit do_sh, input int mode, input int sw);
        logic [DW-1:0] v;
        if (do_sh) begin
            repeat (3) step(1'b1, 1'b0, '0);
            if (m_armed) begin
                exp_err++;
                m_armed = enable;
                m_idx   = 0;
            end else if (enable) begin
                m_armed = 1'b1;
                m_idx   = 0;
            end
            repeat (4) step(1'b0, 1'b0, '0);
        end
        for (int p = 0; p < npix; p++) begin
            for (int off = 0; off < 20; off++) begin
                case (mode)
                    0:       v = DW'($urandom);
                    1:       v = DW'(p);
                    default: v = (off >= sw) ? 12'h555 : 12'hAAA;
                endcase
                step(1'b0, off < 5, v);
                // f2b high at offset 0 is seen as a rise one cycle later (E0 = offset 1);
                // the word present SAMPLE_DLY cycles after E0 is the one captured.
                if (off == 1 + SD && m_armed) begin
                    if (m_idx >= LD && m_idx < LD + AP) begin
                        eq_data.push_back(v);
                        eq_sof.push_back(m_idx == LD);
                        eq_eol.push_back(m_idx == LD + AP - 1);
                    end
                    if (m_idx == LW - 1) begin
                        m_armed = 1'b0;
                        exp_lines++;
                    end else begin
                        m_idx++;
                    end
                end
            end
        end
        repeat (4) step(1'b0, 1'b0, '0);
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b1; sh = 1'b0; f2b = 1'b0; adc = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({pix_valid, pix_sof, pix_eol, line_done, line_err, busy} !== 6'b0 ||
            pix_data !== '0 || line_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_outputs: got flags=%b data=%0h cnt=%0d, want all 0",
                     {pix_valid, pix_sof, pix_eol, line_done, line_err, busy}, pix_data, line_cnt);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_line;
        int bm = mq_data.size();
        int d0 = n_done;
        int b0 = n_busy;
        drive_line(LW, 1'b1, 1, 0);
        tests_run++;
        if (mq_data.size() - bm !== AP) begin
            fails++;
            $display("FAIL basic_count: got %0d pixels, want %0d", mq_data.size() - bm, AP);
        end else begin
            for (int i = 0; i < AP; i++) begin
                tests_run++;
                if (mq_data[bm+i] !== DW'(LD + i) || mq_sof[bm+i] !== (i == 0) ||
                    mq_eol[bm+i] !== (i == AP - 1)) begin
                    fails++;
                    $display("FAIL basic_pix%0d: got data=%0h sof=%0b eol=%0b, want data=%0h sof=%0b eol=%0b",
                             i, mq_data[bm+i], mq_sof[bm+i], mq_eol[bm+i], LD + i, i == 0, i == AP - 1);
                end
            end
        end
        tests_run++;
        if (n_done - d0 !== 1 || line_cnt !== 16'(exp_lines) || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_end: got done=%0d cnt=%0d busy=%0b, want done=1 cnt=%0d busy=0",
                     n_done - d0, line_cnt, busy, exp_lines);
        end
        tests_run++;
        if (n_busy - b0 == 0) begin
            fails++;
            $display("FAIL basic_busy: got busy never high during line, want high");
        end
    endtask

    task automatic test_sample_point;
        int bm = mq_data.size();
        drive_line(LW, 1'b1, 2, 4);
        drive_line(LW, 1'b1, 2, 5);
        tests_run++;
        if (mq_data.size() - bm !== 2 * AP) begin
            fails++;
            $display("FAIL sample_count: got %0d pixels, want %0d", mq_data.size() - bm, 2 * AP);
        end else begin
            tests_run++;
            if (mq_data[bm] !== 12'h555) begin
                fails++;
                $display("FAIL sample_e0p3: got %0h, want 555", mq_data[bm]);
            end
            tests_run++;
            if (mq_data[bm+AP] !== 12'hAAA) begin
                fails++;
                $display("FAIL sample_e0p4: got %0h, want aaa", mq_data[bm+AP]);
            end
        end
    endtask

    task automatic test_sh_abort;
        int bm = mq_data.size();
        int be = eq_data.size();
        int e0 = n_err;
        int c0 = exp_lines;
        int neol = 0;
        drive_line(5, 1'b1, 0, 0);
        drive_line(LW, 1'b1, 0, 0);
        for (int i = bm; i < mq_data.size(); i++) neol += mq_eol[i];
        tests_run++;
        if (n_err - e0 !== 1 || neol !== 1) begin
            fails++;
            $display("FAIL abort_err: got err=%0d eol=%0d, want err=1 eol=1", n_err - e0, neol);
        end
        tests_run++;
        if (line_cnt !== 16'(c0 + 1)) begin
            fails++;
            $display("FAIL abort_cnt: got %0d, want %0d", line_cnt, c0 + 1);
        end
        tests_run++;
        if (mq_data.size() - bm !== eq_data.size() - be) begin
            fails++;
            $display("FAIL abort_len: got %0d pixels, want %0d", mq_data.size() - bm, eq_data.size() - be);
        end else begin
            for (int i = 0; i < eq_data.size() - be; i++) begin
                tests_run++;
                if (mq_data[bm+i] !== eq_data[be+i] || mq_sof[bm+i] !== eq_sof[be+i] ||
                    mq_eol[bm+i] !== eq_eol[be+i]) begin
                    fails++;
                    $display("FAIL abort_pix%0d: got %0h/%0b/%0b, want %0h/%0b/%0b", i,
                             mq_data[bm+i], mq_sof[bm+i], mq_eol[bm+i],
                             eq_data[be+i], eq_sof[be+i], eq_eol[be+i]);
                end
            end
        end
    endtask

    task automatic test_timeout;
        int bm;
        int e0 = n_err;
        drive_line(3, 1'b1, 0, 0);
        repeat (60) step(1'b0, 1'b0, '0);
        m_armed = 1'b0;
        exp_err++;
        tests_run++;
        if (n_err - e0 !== 1 || last_err_cyc - last_valid_cyc !== int'(TO)) begin
            fails++;
            $display("FAIL timeout_err: got err=%0d after %0d cycles, want err=1 after %0d",
                     n_err - e0, last_err_cyc - last_valid_cyc, TO);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_busy: got %0b, want 0", busy);
        end
        bm = mq_data.size();
        drive_line(3, 1'b0, 0, 0);
        tests_run++;
        if (mq_data.size() !== bm || busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_idle: got %0d pixels busy=%0b, want 0 pixels busy=0",
                     mq_data.size() - bm, busy);
        end
    endtask

    task automatic test_reset_mid_line;
        int bm, be;
        int e0 = n_err;
        drive_line(3, 1'b1, 0, 0);
        step(1'b0, 1'b1, 12'h123);
        step(1'b0, 1'b1, 12'h123);
        step(1'b0, 1'b1, 12'h123);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_armed   = 1'b0;
        exp_lines = 0;
        tests_run++;
        if ({pix_valid, pix_sof, pix_eol, line_done, line_err, busy} !== 6'b0 ||
            pix_data !== '0 || line_cnt !== 16'd0) begin
            fails++;
            $display("FAIL rst_mid: got flags=%b data=%0h cnt=%0d, want all 0",
                     {pix_valid, pix_sof, pix_eol, line_done, line_err, busy}, pix_data, line_cnt);
        end
        for (int off = 4; off < 20; off++) step(1'b0, off < 5, 12'h123);
        bm = mq_data.size();
        drive_line(3, 1'b0, 0, 0);
        tests_run++;
        if (mq_data.size() !== bm || n_err !== e0) begin
            fails++;
            $display("FAIL rst_quiet: got %0d pixels err=%0d, want 0 pixels err=0",
                     mq_data.size() - bm, n_err - e0);
        end
        bm = mq_data.size();
        be = eq_data.size();
        drive_line(LW, 1'b1, 0, 0);
        tests_run++;
        if (mq_data.size() - bm !== AP || line_cnt !== 16'(exp_lines)) begin
            fails++;
            $display("FAIL rst_resume: got %0d pixels cnt=%0d, want %0d pixels cnt=%0d",
                     mq_data.size() - bm, line_cnt, AP, exp_lines);
        end else begin
            for (int i = 0; i < AP; i++) begin
                tests_run++;
                if (mq_data[bm+i] !== eq_data[be+i]) begin
                    fails++;
                    $display("FAIL rst_pix%0d: got %0h, want %0h", i, mq_data[bm+i], eq_data[be+i]);
                end
            end
        end
    endtask

    task automatic test_enable;
        int bm = mq_data.size();
        int b0 = n_busy;
        enable = 1'b0;
        drive_line(LW, 1'b1, 0, 0);
        tests_run++;
        if (mq_data.size() !== bm || n_busy !== b0) begin
            fails++;
            $display("FAIL en_off: got %0d pixels busy_cycles=%0d, want 0 and 0",
                     mq_data.size() - bm, n_busy - b0);
        end
        drive_line(2, 1'b1, 0, 0);
        enable = 1'b1;
        drive_line(6, 1'b0, 0, 0);
        tests_run++;
        if (mq_data.size() !== bm || n_busy !== b0) begin
            fails++;
            $display("FAIL en_mid: got %0d pixels busy_cycles=%0d, want 0 and 0",
                     mq_data.size() - bm, n_busy - b0);
        end
        drive_line(LW, 1'b1, 1, 0);
        tests_run++;
        if (mq_data.size() - bm !== AP || line_cnt !== 16'(exp_lines)) begin
            fails++;
            $display("FAIL en_rearm: got %0d pixels cnt=%0d, want %0d pixels cnt=%0d",
                     mq_data.size() - bm, line_cnt, AP, exp_lines);
        end
    endtask

    task automatic test_back_to_back;
        int bm = mq_data.size();
        int be = eq_data.size();
        repeat (3) drive_line(LW, 1'b1, 0, 0);
        tests_run++;
        if (mq_data.size() - bm !== eq_data.size() - be) begin
            fails++;
            $display("FAIL b2b_len: got %0d pixels, want %0d", mq_data.size() - bm, eq_data.size() - be);
        end else begin
            for (int i = 0; i < eq_data.size() - be; i++) begin
                tests_run++;
                if (mq_data[bm+i] !== eq_data[be+i] || mq_sof[bm+i] !== eq_sof[be+i] ||
                    mq_eol[bm+i] !== eq_eol[be+i]) begin
                    fails++;
                    $display("FAIL b2b_pix%0d: got %0h/%0b/%0b, want %0h/%0b/%0b", i,
                             mq_data[bm+i], mq_sof[bm+i], mq_eol[bm+i],
                             eq_data[be+i], eq_sof[be+i], eq_eol[be+i]);
                end
            end
        end
        tests_run++;
        if (line_cnt !== 16'(exp_lines) || n_err !== exp_err) begin
            fails++;
            $display("FAIL b2b_counts: got cnt=%0d err=%0d, want cnt=%0d err=%0d",
                     line_cnt, n_err, exp_lines, exp_err);
        end
    endtask

    initial begin
        test_reset;
        test_basic_line;
        test_sample_point;
        test_sh_abort;
        test_timeout;
        test_reset_mid_line;
        test_enable;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
